// File: rtl/network_interface_if.sv
// Bundle of core-side request/response and router-side packet signals for
// the network interface. The slave modport is the network interface itself;
// the master modport is whatever sits around it (core plus router port).
interface network_interface_if #(
    parameter int NET_ADDR_W  = 4,
    parameter int BANK_ADDR_W = 8,
    parameter int DATA_W      = 32
);
    // Core request/response
    logic                              req_valid;
    logic                              req_ready;
    logic                              req_write;
    logic [NET_ADDR_W+BANK_ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0]                 req_wdata;
    logic                              resp_valid;
    logic [DATA_W-1:0]                 resp_rdata;
    logic                              resp_error;

    // Router injection port
    logic                              portEnable;
    logic [NET_ADDR_W+BANK_ADDR_W-1:0] destinationAddressOut;
    logic [NET_ADDR_W-1:0]             requesterAddressOut;
    logic                              readOut;
    logic                              writeOut;
    logic [DATA_W-1:0]                 dataOut;

    // Router ejection port
    logic [NET_ADDR_W+BANK_ADDR_W-1:0] destinationAddressIn;
    logic [NET_ADDR_W-1:0]             requesterAddressIn;
    logic                              readIn;
    logic                              writeIn;
    logic [DATA_W-1:0]                 dataIn;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  portEnable,
        input  destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output portEnable,
        output destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut
    );
endinterface

// File: rtl/network_interface.sv
// Core-side injection/ejection stage in front of one router mesh port.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_ready is high only while idle, and the request
// is copied into local registers so the core may change its inputs after.
// One transaction is outstanding at a time; resp_valid is a one-cycle pulse.
module network_interface #(
    parameter int NET_ADDR_W  = 4,
    parameter int BANK_ADDR_W = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NET_ADDR_W-1:0] localRouterAddress,
    network_interface_if.slave    bus,
    output logic [1:0]            dbg_state_o
);
    localparam int ADDR_W = NET_ADDR_W + BANK_ADDR_W;
    localparam int CNT_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                error_q, error_d;
    logic                reply_match;

    // Only the node part of the incoming destination matters for matching.
    logic unused_bank_bits;
    assign unused_bank_bits = ^bus.destinationAddressIn[BANK_ADDR_W-1:0];

    // A reply is a write packet addressed back to this node for this node.
    assign reply_match = bus.writeIn && !bus.readIn
                      && (bus.destinationAddressIn[ADDR_W-1:BANK_ADDR_W] == localRouterAddress)
                      && (bus.requesterAddressIn == localRouterAddress);

    // State and transaction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Next-state logic: capture, inject, wait for reply or time out, report.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    // Loads carry no payload on the network.
                    wdata_d = bus.req_write ? bus.req_wdata : '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.portEnable) begin
                    if (write_q) begin
                        rdata_d = '0;
                        error_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // A reply on the terminal-count cycle still wins.
                if (reply_match) begin
                    rdata_d = bus.dataIn;
                    error_d = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only; nothing flows from core inputs.
    always_comb begin
        bus.req_ready             = (state_q == IDLE);
        bus.readOut               = (state_q == SEND) && !write_q;
        bus.writeOut              = (state_q == SEND) && write_q;
        bus.destinationAddressOut = (state_q == SEND) ? addr_q : '0;
        bus.dataOut               = (state_q == SEND) ? wdata_q : '0;
        bus.requesterAddressOut   = localRouterAddress;
        bus.resp_valid            = (state_q == DONE);
        bus.resp_rdata            = (state_q == DONE) ? rdata_q : '0;
        bus.resp_error            = (state_q == DONE) && error_q;
        dbg_state_o               = state_q;
    end
endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface: a transaction-level model predicts
// every output each cycle, and directed scenarios pin key values by hand.
module tb_network_interface;
    localparam int NA = 4;
    localparam int BA = 8;
    localparam int DW = 32;
    localparam int TO = 64;
    localparam int AW = NA + BA;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NA-1:0] local_addr = 4'd4;
    logic [1:0]    dbg_state;
    int            cyc = 0;

    network_interface_if #(.NET_ADDR_W(NA), .BANK_ADDR_W(BA), .DATA_W(DW)) bus();

    network_interface #(
        .NET_ADDR_W(NA), .BANK_ADDR_W(BA), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .localRouterAddress(local_addr),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model of what the outputs must be.
    bit            m_busy, m_pkt, m_wait, m_resp, m_err, m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    int            m_waited;

    function automatic bit reply_ok();
        return bus.writeIn && !bus.readIn
            && (bus.destinationAddressIn[AW-1:BA] == local_addr)
            && (bus.requesterAddressIn == local_addr);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_pkt <= 0; m_wait <= 0; m_resp <= 0; m_err <= 0;
            m_write <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_waited <= 0;
        end else if (m_resp) begin
            m_resp <= 0;
            m_busy <= 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy  <= 1;
                m_pkt   <= 1;
                m_write <= bus.req_write;
                m_addr  <= bus.req_addr;
                m_wdata <= bus.req_write ? bus.req_wdata : '0;
            end
        end else if (m_pkt) begin
            if (bus.portEnable) begin
                m_pkt <= 0;
                if (m_write) begin
                    m_resp <= 1; m_rdata <= '0; m_err <= 0;
                end else begin
                    m_wait <= 1; m_waited <= 0;
                end
            end
        end else if (m_wait) begin
            if (reply_ok()) begin
                m_wait <= 0; m_resp <= 1; m_rdata <= bus.dataIn; m_err <= 0;
            end else if (m_waited == TO - 1) begin
                m_wait <= 0; m_resp <= 1; m_rdata <= '0; m_err <= 1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("req_ready",   32'(bus.req_ready),  32'(!m_busy));
            chk("readOut",     32'(bus.readOut),    32'(m_pkt && !m_write));
            chk("writeOut",    32'(bus.writeOut),   32'(m_pkt && m_write));
            chk("destOut",     32'(bus.destinationAddressOut), m_pkt ? 32'(m_addr) : 32'd0);
            chk("dataOut",     bus.dataOut,         m_pkt ? m_wdata : 32'd0);
            chk("requesterOut", 32'(bus.requesterAddressOut), 32'(local_addr));
            chk("resp_valid",  32'(bus.resp_valid), 32'(m_resp));
            chk("resp_rdata",  bus.resp_rdata,      m_resp ? m_rdata : 32'd0);
            chk("resp_error",  32'(bus.resp_error), 32'(m_resp && m_err));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic set_reply(input logic w, input logic r, input logic [AW-1:0] dst,
                             input logic [NA-1:0] rq, input logic [DW-1:0] d);
        bus.writeIn              = w;
        bus.readIn               = r;
        bus.destinationAddressIn = dst;
        bus.requesterAddressIn   = rq;
        bus.dataIn               = d;
    endtask

    task automatic clear_reply();
        set_reply(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        summary();
        $finish;
    end

    initial begin
        set_req(1'b0, 1'b0, '0, '0);
        bus.portEnable = 1'b0;
        clear_reply();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst req_ready",  32'(bus.req_ready), 32'd1);
        chk("rst readOut",    32'(bus.readOut), 32'd0);
        chk("rst writeOut",   32'(bus.writeOut), 32'd0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst requester",  32'(bus.requesterAddressOut), 32'd4);
        chk("rst state",      32'(dbg_state), 32'd0);

        // Store, port open: one-cycle packet, response two cycles after accept
        bus.portEnable = 1'b1;
        set_req(1'b1, 1'b1, {4'd8, 8'h10}, 32'hA5);
        tick();
        chk("st writeOut", 32'(bus.writeOut), 32'd1);
        chk("st readOut",  32'(bus.readOut), 32'd0);
        chk("st dest",     32'(bus.destinationAddressOut), 32'h810);
        chk("st data",     bus.dataOut, 32'hA5);
        set_req(1'b0, 1'b0, 12'hFFF, 32'hDEAD);
        tick();
        chk("st resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("st resp_error", 32'(bus.resp_error), 32'd0);
        chk("st resp_rdata", bus.resp_rdata, 32'd0);
        chk("st pkt gone",   32'(bus.writeOut), 32'd0);
        tick();
        chk("st pulse end", 32'(bus.resp_valid), 32'd0);
        chk("st ready",     32'(bus.req_ready), 32'd1);

        // Load with port blocked for 3 cycles, then a reply
        bus.portEnable = 1'b0;
        set_req(1'b1, 1'b0, {4'd2, 8'h03}, 32'h55);
        tick();
        set_req(1'b0, 1'b1, 12'hABC, 32'h99);
        for (int i = 0; i < 4; i++) begin
            chk("ld readOut held", 32'(bus.readOut), 32'd1);
            chk("ld dest held",    32'(bus.destinationAddressOut), 32'h203);
            chk("ld data zero",    bus.dataOut, 32'd0);
            // A matching reply while still sending is dropped.
            if (i == 1) set_reply(1'b1, 1'b0, {4'd4, 8'h00}, 4'd4, 32'hBAD0);
            else clear_reply();
            if (i == 3) bus.portEnable = 1'b1;
            tick();
        end
        chk("ld injected", 32'(bus.readOut), 32'd0);
        bus.portEnable = 1'b0;
        set_reply(1'b0, 1'b1, {4'd4, 8'h01}, 4'd4, 32'hBAD1);
        repeat (4) begin
            tick();
            clear_reply();
        end
        set_reply(1'b1, 1'b0, {4'd4, 8'h77}, 4'd4, 32'h1234);
        tick();
        clear_reply();
        chk("ld resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("ld resp_rdata", bus.resp_rdata, 32'h1234);
        chk("ld resp_error", 32'(bus.resp_error), 32'd0);
        tick();

        // Load with no matching reply: timeout 64 cycles after the send edge
        bus.portEnable = 1'b1;
        set_req(1'b1, 1'b0, {4'd3, 8'h01}, 32'h0);
        tick();
        set_req(1'b0, 1'b0, '0, '0);
        tick();
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k < TO) chk("to quiet", 32'(bus.resp_valid), 32'd0);
            case (k)
                10: set_reply(1'b1, 1'b0, {4'd4, 8'h02}, 4'd6, 32'h6666);
                20: set_reply(1'b1, 1'b0, {4'd5, 8'h02}, 4'd4, 32'h5555);
                30: set_reply(1'b0, 1'b1, {4'd4, 8'h02}, 4'd4, 32'h4444);
                default: clear_reply();
            endcase
        end
        clear_reply();
        chk("to resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("to resp_error", 32'(bus.resp_error), 32'd1);
        chk("to resp_rdata", bus.resp_rdata, 32'd0);
        tick();

        // Reply on the terminal-count cycle wins; next request held on valid
        set_req(1'b1, 1'b0, {4'd7, 8'h44}, 32'h0);
        tick();
        set_req(1'b1, 1'b1, {4'd1, 8'h22}, 32'h77);
        tick();
        repeat (TO - 1) tick();
        set_reply(1'b1, 1'b0, {4'd4, 8'hEE}, 4'd4, 32'hCAFE0001);
        tick();
        clear_reply();
        chk("tc resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("tc resp_error", 32'(bus.resp_error), 32'd0);
        chk("tc resp_rdata", bus.resp_rdata, 32'hCAFE0001);
        chk("tc not ready",  32'(bus.req_ready), 32'd0);
        tick();
        chk("b2b ready", 32'(bus.req_ready), 32'd1);
        tick();
        set_req(1'b0, 1'b0, '0, '0);
        chk("b2b writeOut", 32'(bus.writeOut), 32'd1);
        chk("b2b dest",     32'(bus.destinationAddressOut), 32'h122);
        chk("b2b data",     bus.dataOut, 32'h77);
        tick();
        chk("b2b resp", 32'(bus.resp_valid), 32'd1);
        tick();

        // Reset during the wait abandons the load; a late reply is ignored
        set_req(1'b1, 1'b0, {4'd9, 8'h09}, 32'h0);
        tick();
        set_req(1'b0, 1'b0, '0, '0);
        tick();
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("mid rst ready", 32'(bus.req_ready), 32'd1);
        chk("mid rst resp",  32'(bus.resp_valid), 32'd0);
        tick();
        reset = 1'b0;
        set_reply(1'b1, 1'b0, {4'd4, 8'h09}, 4'd4, 32'hFEED);
        repeat (3) begin
            tick();
            chk("late reply resp", 32'(bus.resp_valid), 32'd0);
            chk("late reply ready", 32'(bus.req_ready), 32'd1);
        end
        chk("late reply state", 32'(dbg_state), 32'd0);
        clear_reply();
        tick();

        summary();
        $finish;
    end
endmodule
